// File: rtl/alu_flags.sv
// ============================================================================
//  Module   : alu_flags
//  Purpose  : 8-bit combinational ALU with registered carry/zero flags and
//             a one-deep shadow copy of the flags for interrupt entry/exit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_flags (
    input  logic       clk,
    input  logic       RST,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] SEL,
    input  logic       FLG_LD,
    input  logic       FLG_C_SET,
    input  logic       FLG_C_CLR,
    input  logic       FLG_SHAD_LD,
    input  logic       FLG_LD_SEL,
    output logic [7:0] RESULT,
    output logic       C_FLAG,
    output logic       Z_FLAG
);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_ADDC = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_SUBC = 4'd3;
    localparam logic [3:0] c_OP_CMP  = 4'd4;
    localparam logic [3:0] c_OP_AND  = 4'd5;
    localparam logic [3:0] c_OP_OR   = 4'd6;
    localparam logic [3:0] c_OP_EXOR = 4'd7;
    localparam logic [3:0] c_OP_TEST = 4'd8;
    localparam logic [3:0] c_OP_LSL  = 4'd9;
    localparam logic [3:0] c_OP_LSR  = 4'd10;
    localparam logic [3:0] c_OP_ROL  = 4'd11;
    localparam logic [3:0] c_OP_ROR  = 4'd12;
    localparam logic [3:0] c_OP_ASR  = 4'd13;
    localparam logic [3:0] c_OP_MOV  = 4'd14;

    logic       r_c_flag;
    logic       r_z_flag;
    logic       r_shad_c;
    logic       r_shad_z;
    logic [8:0] w_ext;
    logic [7:0] w_result;
    logic       w_co;
    logic       w_zero;
    logic       w_cin;

    assign w_cin = r_c_flag;

    // Arithmetic ops run 9 bits wide; bit 8 is carry for add and borrow for subtract.
    always_comb begin
        w_ext    = 9'd0;
        w_result = 8'h00;
        w_co     = 1'b0;
        case (SEL)
            c_OP_ADD: begin
                w_ext    = {1'b0, A} + {1'b0, B};
                w_result = w_ext[7:0];
                w_co     = w_ext[8];
            end
            c_OP_ADDC: begin
                w_ext    = {1'b0, A} + {1'b0, B} + {8'd0, w_cin};
                w_result = w_ext[7:0];
                w_co     = w_ext[8];
            end
            c_OP_SUB, c_OP_CMP: begin
                w_ext    = {1'b0, A} - {1'b0, B};
                w_result = w_ext[7:0];
                w_co     = w_ext[8];
            end
            c_OP_SUBC: begin
                w_ext    = {1'b0, A} - {1'b0, B} - {8'd0, w_cin};
                w_result = w_ext[7:0];
                w_co     = w_ext[8];
            end
            c_OP_AND, c_OP_TEST: w_result = A & B;
            c_OP_OR:             w_result = A | B;
            c_OP_EXOR:           w_result = A ^ B;
            c_OP_LSL: begin
                w_result = {A[6:0], w_cin};
                w_co     = A[7];
            end
            c_OP_LSR: begin
                w_result = {w_cin, A[7:1]};
                w_co     = A[0];
            end
            c_OP_ROL: begin
                w_result = {A[6:0], A[7]};
                w_co     = A[7];
            end
            c_OP_ROR: begin
                w_result = {A[0], A[7:1]};
                w_co     = A[0];
            end
            c_OP_ASR: begin
                w_result = {A[7], A[7:1]};
                w_co     = A[0];
            end
            c_OP_MOV: begin
                w_result = B;
                w_co     = w_cin;
            end
            default: begin
                w_result = 8'h00;
                w_co     = 1'b0;
            end
        endcase
    end

    assign w_zero = (w_result == 8'h00);

    // Shadow capture reads the pre-edge flags, so a simultaneous restore swaps.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_c_flag <= 1'b0;
            r_z_flag <= 1'b0;
            r_shad_c <= 1'b0;
            r_shad_z <= 1'b0;
        end else begin
            if (FLG_LD_SEL)     r_c_flag <= r_shad_c;
            else if (FLG_C_SET) r_c_flag <= 1'b1;
            else if (FLG_C_CLR) r_c_flag <= 1'b0;
            else if (FLG_LD)    r_c_flag <= w_co;

            if (FLG_LD_SEL)     r_z_flag <= r_shad_z;
            else if (FLG_LD)    r_z_flag <= w_zero;

            if (FLG_SHAD_LD) begin
                r_shad_c <= r_c_flag;
                r_shad_z <= r_z_flag;
            end
        end
    end

    assign RESULT = w_result;
    assign C_FLAG = r_c_flag;
    assign Z_FLAG = r_z_flag;

endmodule

`default_nettype wire

// File: tb/tb_alu_flags.sv
// Self-checking bench for alu_flags: directed scenarios then randomized steps,
// compared against an arithmetic reference model of the ALU and flag rules.
`default_nettype none

module tb_alu_flags;

    logic       clk = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [3:0] SEL = 4'd0;
    logic       FLG_LD = 1'b0;
    logic       FLG_C_SET = 1'b0;
    logic       FLG_C_CLR = 1'b0;
    logic       FLG_SHAD_LD = 1'b0;
    logic       FLG_LD_SEL = 1'b0;
    logic [7:0] RESULT;
    logic       C_FLAG;
    logic       Z_FLAG;

    int tests = 0;
    int fails = 0;

    // reference model state
    int m_c = 0, m_z = 0, m_sc = 0, m_sz = 0;

    alu_flags dut (
        .clk        (clk),
        .RST        (RST),
        .A          (A),
        .B          (B),
        .SEL        (SEL),
        .FLG_LD     (FLG_LD),
        .FLG_C_SET  (FLG_C_SET),
        .FLG_C_CLR  (FLG_C_CLR),
        .FLG_SHAD_LD(FLG_SHAD_LD),
        .FLG_LD_SEL (FLG_LD_SEL),
        .RESULT     (RESULT),
        .C_FLAG     (C_FLAG),
        .Z_FLAG     (Z_FLAG)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU: plain integer arithmetic on operand values.
    task automatic model_alu(input int a, input int b, input int sel, input int cin,
                             output int r, output int co);
        int s;
        r = 0; co = 0;
        case (sel)
            0:  begin s = a + b;       r = s % 256; co = (s > 255); end
            1:  begin s = a + b + cin; r = s % 256; co = (s > 255); end
            2, 4: begin r = (a - b + 256) % 256; co = (a < b); end
            3:  begin r = (a - b - cin + 512) % 256; co = (a < b + cin); end
            5, 8: r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            9:  begin r = (a * 2 + cin) % 256; co = a / 128; end
            10: begin r = cin * 128 + a / 2;   co = a % 2; end
            11: begin r = (a * 2) % 256 + a / 128; co = a / 128; end
            12: begin r = (a % 2) * 128 + a / 2;  co = a % 2; end
            13: begin r = (a / 128) * 128 + a / 2; co = a % 2; end
            14: begin r = b; co = cin; end
            default: begin r = 0; co = 0; end
        endcase
    endtask

    // ctl = {rst, ld_sel, shad_ld, c_set, c_clr, ld}; er/ec/ez = -1 to skip the explicit check
    task automatic step(input string tag, input int a, input int b, input int sel,
                        input logic [5:0] ctl, input int er, input int ec, input int ez);
        int r, co, nc, nz;
        @(negedge clk);
        A = a[7:0]; B = b[7:0]; SEL = sel[3:0];
        {RST, FLG_LD_SEL, FLG_SHAD_LD, FLG_C_SET, FLG_C_CLR, FLG_LD} = ctl;
        #1;
        model_alu(a, b, sel, m_c, r, co);
        chk({tag, ".result"}, RESULT, r[7:0]);
        if (er >= 0) chk({tag, ".result_dir"}, RESULT, er[7:0]);
        if (ctl[5])      begin nc = 0; nz = 0; end
        else begin
            if (ctl[4])      nc = m_sc;
            else if (ctl[2]) nc = 1;
            else if (ctl[1]) nc = 0;
            else if (ctl[0]) nc = co;
            else             nc = m_c;
            if (ctl[4])      nz = m_sz;
            else if (ctl[0]) nz = (r == 0);
            else             nz = m_z;
        end
        if (ctl[5])      begin m_sc = 0; m_sz = 0; end
        else if (ctl[3]) begin m_sc = m_c; m_sz = m_z; end
        m_c = nc; m_z = nz;
        @(posedge clk);
        #1;
        chk({tag, ".c"}, {7'd0, C_FLAG}, m_c[7:0]);
        chk({tag, ".z"}, {7'd0, Z_FLAG}, m_z[7:0]);
        if (ec >= 0) chk({tag, ".c_dir"}, {7'd0, C_FLAG}, ec[7:0]);
        if (ez >= 0) chk({tag, ".z_dir"}, {7'd0, Z_FLAG}, ez[7:0]);
    endtask

    initial begin
        // reset
        step("reset", 0, 0, 0, 6'b100000, 0, 0, 0);
        step("reset2", 8'h12, 8'h34, 14, 6'b100111, 8'h34, 0, 0);
        // add wrap to zero, then ADDC consuming carry
        step("add_ff", 8'hFF, 8'h01, 0, 6'b000001, 8'h00, 1, 1);
        step("addc",   8'h10, 8'h05, 1, 6'b000001, 8'h16, 0, 0);
        // subtraction with borrow
        step("sub",    8'h03, 8'h05, 2, 6'b000001, 8'hFE, 1, 0);
        step("subc",   8'h05, 8'h05, 3, 6'b000001, 8'hFF, 1, 0);
        // shifts with C=1 and A=0x81
        step("lsl", 8'h81, 0, 9,  6'b000001, 8'h03, 1, 0);
        step("lsr", 8'h81, 0, 10, 6'b000001, 8'hC0, 1, 0);
        step("asr", 8'h81, 0, 13, 6'b000001, 8'hC0, 1, 0);
        step("rol", 8'h81, 0, 11, 6'b000001, 8'h03, 1, 0);
        step("ror", 8'h81, 0, 12, 6'b000001, 8'hC0, 1, 0);
        // shadow save, modify, restore, set/clr priority, reset discards load
        step("shad_save",  0, 0, 15, 6'b001000, 8'h00, 1, 0);
        step("clr_ld",     0, 0, 15, 6'b000011, 8'h00, 0, 1);
        step("restore",    0, 0, 15, 6'b010000, 8'h00, 1, 0);
        step("set_clr",    0, 0, 15, 6'b000110, -1, 1, 0);
        step("rst_ld",     8'hFF, 8'h01, 0, 6'b101001, -1, 0, 0);
        // swap
        step("swap_pre1",  0, 0, 15, 6'b000100, -1, 1, 0);
        step("swap_pre2",  0, 0, 15, 6'b001000, -1, 1, 0);
        step("swap_pre3",  0, 0, 15, 6'b000001, -1, 0, 1);
        step("swap",       0, 0, 15, 6'b011000, -1, 1, 0);
        step("swap_chk",   0, 0, 15, 6'b010000, -1, 0, 1);
        // reset discards shadow load
        step("rst_shad",   0, 0, 15, 6'b101000, -1, 0, 0);
        step("rst_shad2",  0, 0, 15, 6'b000100, -1, 1, 0);
        step("rst_shad3",  0, 0, 15, 6'b010000, -1, 0, 0);
        // randomized
        for (int i = 0; i < 400; i++) begin
            logic [5:0] ctl;
            ctl[5] = ($urandom_range(0, 15) == 0);
            ctl[4] = ($urandom_range(0, 5) == 0);
            ctl[3] = ($urandom_range(0, 4) == 0);
            ctl[2] = ($urandom_range(0, 5) == 0);
            ctl[1] = ($urandom_range(0, 5) == 0);
            ctl[0] = ($urandom_range(0, 1) == 0);
            step("rand", $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 15), ctl, -1, -1, -1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
